data_sram_responder: RTL and testbench

Data-side responder for the CPU core's data SRAM interface: it accepts the core's `data_sram_*` requests and returns read data one cycle later. It also decodes a small confreg-style MMIO window: LED, number display, switch input, and a free-running timer. It sits outside `mycpu_top` and drives its `data_sram_rdata` input. It replaces the bare RAM so the core can run self-checking programs and talk to board I/O.

---
 rtl/data_sram_responder_if.sv | 24 ++
 rtl/data_sram_responder.sv | 106 ++++++++++
 tb/tb_data_sram_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/data_sram_responder_if.sv
// rtl/data_sram_responder_if.sv - data SRAM request/response bundle between core and responder
interface data_sram_responder_if;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_en,
      output data_sram_wen,
      output data_sram_addr,
      output data_sram_wdata,
      input  data_sram_rdata
   );

   modport slave (
      input  data_sram_en,
      input  data_sram_wen,
      input  data_sram_addr,
      input  data_sram_wdata,
      output data_sram_rdata
   );
endinterface

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data-side RAM plus confreg MMIO window with 1-cycle read latency
module data_sram_responder #(
   parameter int          RAM_ADDR_W = 12,
   parameter logic [31:0] CONF_BASE  = 32'hBFAF_0000,
   parameter logic [31:0] CONF_MASK  = 32'hFFFF_0000
) (
   input  logic                        clk,
   input  logic                        reset,
   data_sram_responder_if.slave        bus,
   input  logic [7:0]                  switch,
   output logic [15:0]                 led,
   output logic [31:0]                 num_data,
   output logic                        access_err
);

   localparam int RAM_WORDS = 1 << RAM_ADDR_W;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
      return r;
   endfunction

   logic [31:0]           mem [RAM_WORDS];
   logic [31:0]           ram_q;
   logic [31:0]           conf_q;
   logic                  sel_ram;
   logic [31:0]           timer;

   logic                  req;
   logic                  wr;
   logic                  conf_hit;
   logic                  ram_hit;
   logic [RAM_ADDR_W-1:0] ram_idx;
   logic [15:0]           offset;
   logic                  sel_led;
   logic                  sel_num;
   logic                  sel_timer;
   logic [31:0]           conf_rd;
   logic [31:0]           led_m;
   logic [31:0]           num_m;
   logic [31:0]           timer_m;

   // A request in the reset cycle is discarded entirely.
   assign req       = bus.data_sram_en && !reset;
   assign wr        = |bus.data_sram_wen;
   assign conf_hit  = (bus.data_sram_addr & CONF_MASK) == CONF_BASE;
   assign ram_hit   = !conf_hit && (bus.data_sram_addr[31:RAM_ADDR_W+2] == '0);
   assign ram_idx   = bus.data_sram_addr[RAM_ADDR_W+1:2];
   assign offset    = bus.data_sram_addr[15:0];
   assign sel_led   = conf_hit && (offset == 16'hF000);
   assign sel_num   = conf_hit && (offset == 16'hF010);
   assign sel_timer = conf_hit && (offset == 16'hE000);

   assign led_m     = merge({16'h0000, led}, bus.data_sram_wdata, bus.data_sram_wen);
   assign num_m     = merge(num_data, bus.data_sram_wdata, bus.data_sram_wen);
   assign timer_m   = merge(timer, bus.data_sram_wdata, bus.data_sram_wen);

   always_comb begin
      conf_rd = '0;
      if (conf_hit) begin
         unique case (offset)
            16'hF000: conf_rd = {16'h0000, led};
            16'hF010: conf_rd = num_data;
            16'hF020: conf_rd = {24'h000000, switch};
            16'hE000: conf_rd = timer;
            default:  conf_rd = '0;
         endcase
      end
   end

   // Read-first single-port RAM; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (req && ram_hit) begin
         ram_q <= mem[ram_idx];
         for (int i = 0; i < 4; i++)
            if (bus.data_sram_wen[i]) mem[ram_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_ram    <= 1'b0;
         conf_q     <= '0;
         led        <= '0;
         num_data   <= '0;
         timer      <= '0;
         access_err <= 1'b0;
      end else begin
         timer <= (req && wr && sel_timer) ? timer_m : timer + 32'd1;
         if (req) begin
            sel_ram <= ram_hit;
            conf_q  <= conf_rd;
            if (wr && sel_led) led      <= led_m[15:0];
            if (wr && sel_num) num_data <= num_m;
            if (!conf_hit && !ram_hit) access_err <= 1'b1;
         end
      end
   end

   assign bus.data_sram_rdata = sel_ram ? ram_q : conf_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - scoreboard bench for data_sram_responder
module tb_data_sram_responder;

   typedef struct {
      bit          chk;
      logic [31:0] exp;
      string       name;
   } sb_entry_t;

   logic        clk;
   logic        reset;
   logic [7:0]  switch;
   logic [15:0] led;
   logic [31:0] num_data;
   logic        access_err;
   bit          pend;
   int          checks;
   int          failures;
   sb_entry_t   sb[$];

   data_sram_responder_if bus();

   data_sram_responder dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .switch     (switch),
      .led        (led),
      .num_data   (num_data),
      .access_err (access_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Called at a negedge: drive one request, queue its expectation, wait to the next negedge.
   task automatic issue(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit chk, input logic [31:0] exp, input string name);
      sb_entry_t e;
      bus.data_sram_en    = 1'b1;
      bus.data_sram_wen   = wen;
      bus.data_sram_addr  = addr;
      bus.data_sram_wdata = wdata;
      e.chk  = chk;
      e.exp  = exp;
      e.name = name;
      sb.push_back(e);
      @(negedge clk);
      bus.data_sram_en = 1'b0;
   endtask

   task automatic idle();
      bus.data_sram_en = 1'b0;
      @(negedge clk);
   endtask

   always @(posedge clk) pend <= bus.data_sram_en && !reset;

   always @(negedge clk) begin
      sb_entry_t e;
      if (pend) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow actual=empty required=entry");
         end else begin
            e = sb.pop_front();
            if (e.chk) check32(e.name, bus.data_sram_rdata, e.exp);
         end
      end
   end

   initial begin
      reset               = 1'b1;
      switch              = 8'hA5;
      bus.data_sram_en    = 1'b0;
      bus.data_sram_wen   = 4'h0;
      bus.data_sram_addr  = '0;
      bus.data_sram_wdata = '0;
      repeat (2) @(negedge clk);
      check32("reset_rdata", bus.data_sram_rdata, 32'h0);
      check32("reset_led", {16'h0, led}, 32'h0);
      check32("reset_num", num_data, 32'h0);
      check32("reset_err", {31'h0, access_err}, 32'h0);
      reset = 1'b0;

      // RAM byte lanes and read-first
      issue(4'hF, 32'h0000_0000, 32'hCAFE_F00D, 0, 32'h0, "w0");
      issue(4'hF, 32'h0000_0100, 32'hAABB_CCDD, 0, 32'h0, "w100");
      issue(4'b0101, 32'h0000_0100, 32'h1122_3344, 1, 32'hAABB_CCDD, "ram_rfirst_partial");
      issue(4'h0, 32'h0000_0100, 32'h0, 1, 32'hAA22_CC44, "ram_byte_merge");
      issue(4'hF, 32'h0000_0004, 32'h0000_0007, 0, 32'h0, "w4_old");
      idle();
      issue(4'hF, 32'h0000_0004, 32'h0000_0055, 1, 32'h0000_0007, "ram_rfirst");
      issue(4'h0, 32'h0000_0004, 32'h0, 1, 32'h0000_0055, "ram_b2b_1");
      issue(4'h0, 32'h0000_0004, 32'h0, 1, 32'h0000_0055, "ram_b2b_2");

      // MMIO registers, interleaved with RAM reads
      issue(4'hF, 32'hBFAF_F000, 32'h0000_FFFF, 0, 32'h0, "w_led");
      check32("led_write", {16'h0, led}, 32'h0000_FFFF);
      issue(4'h0, 32'hBFAF_F000, 32'h0, 1, 32'h0000_FFFF, "led_read");
      issue(4'hF, 32'hBFAF_F010, 32'h1234_5678, 0, 32'h0, "w_num");
      check32("num_write", num_data, 32'h1234_5678);
      issue(4'h0, 32'hBFAF_F010, 32'h0, 1, 32'h1234_5678, "num_read");
      issue(4'b1000, 32'hBFAF_F010, 32'hAABB_CCDD, 0, 32'h0, "w_num_b3");
      check32("num_byte_write", num_data, 32'hAA34_5678);
      issue(4'h0, 32'h0000_0100, 32'h0, 1, 32'hAA22_CC44, "mix_ram");
      issue(4'h0, 32'hBFAF_F010, 32'h0, 1, 32'hAA34_5678, "mix_num");
      issue(4'h0, 32'hBFAF_F020, 32'h0, 1, 32'h0000_00A5, "switch_read");
      issue(4'hF, 32'hBFAF_F020, 32'hFFFF_FFFF, 0, 32'h0, "w_switch");
      issue(4'h0, 32'hBFAF_F020, 32'h0, 1, 32'h0000_00A5, "switch_ro");
      issue(4'h0, 32'hBFAF_F030, 32'h0, 1, 32'h0, "unmapped_read");
      check32("unmapped_no_err", {31'h0, access_err}, 32'h0);

      // Timer wrap: one RAM read between the load and the first timer read
      issue(4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE, 0, 32'h0, "w_timer");
      issue(4'h0, 32'h0000_0100, 32'h0, 1, 32'hAA22_CC44, "timer_gap_ram");
      issue(4'h0, 32'hBFAF_E000, 32'h0, 1, 32'hFFFF_FFFF, "timer_0");
      issue(4'h0, 32'hBFAF_E000, 32'h0, 1, 32'h0000_0000, "timer_wrap");
      issue(4'h0, 32'hBFAF_E000, 32'h0, 1, 32'h0000_0001, "timer_2");

      // Out of range
      issue(4'h0, 32'h0000_4000, 32'h0, 1, 32'h0, "oor_read");
      check32("oor_err_set", {31'h0, access_err}, 32'h1);
      issue(4'hF, 32'h0000_4000, 32'hDEAD_BEEF, 0, 32'h0, "w_oor");
      issue(4'h0, 32'h0000_0000, 32'h0, 1, 32'hCAFE_F00D, "oor_ram_intact");
      idle();
      check32("oor_err_sticky", {31'h0, access_err}, 32'h1);

      // Reset with a NUM read in flight; that request is discarded
      reset               = 1'b1;
      bus.data_sram_en    = 1'b1;
      bus.data_sram_wen   = 4'h0;
      bus.data_sram_addr  = 32'hBFAF_F010;
      @(posedge clk);
      #1;
      check32("rst_rdata", bus.data_sram_rdata, 32'h0);
      check32("rst_led", {16'h0, led}, 32'h0);
      check32("rst_num", num_data, 32'h0);
      check32("rst_err", {31'h0, access_err}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      issue(4'h0, 32'hBFAF_E000, 32'h0, 1, 32'h0000_0000, "rst_timer_0");
      issue(4'h0, 32'hBFAF_E000, 32'h0, 1, 32'h0000_0001, "rst_timer_1");
      issue(4'h0, 32'h0000_0100, 32'h0, 1, 32'hAA22_CC44, "rst_ram_intact");
      issue(4'h0, 32'h0000_0000, 32'h0, 1, 32'hCAFE_F00D, "rst_ram0_intact");
      idle();
      idle();
      check32("sb_drained", sb.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
